// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: FWFT buffer of retired instructions tagged with sequence numbers, with drop accounting.
// Define COMMIT_TRACE_SKIP_X0_EN to ignore commits whose destination is x0.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     debug_commit,
  input  logic [63:0]              debug_pc,
  input  logic [4:0]               debug_reg_num,
  input  logic [63:0]              debug_wdata,
  input  logic                     clear,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [63:0]              trace_pc,
  output logic [4:0]               trace_reg_num,
  output logic [63:0]              trace_wdata,
  output logic [SEQ_W-1:0]         trace_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [SEQ_W-1:0]         drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [63:0]      r_pc  [DEPTH];
  logic [4:0]       r_rd  [DEPTH];
  logic [63:0]      r_wd  [DEPTH];
  logic [SEQ_W-1:0] r_sq  [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic [SEQ_W-1:0] r_seq, r_drop;
  logic             r_ovf;
  logic             w_elig, w_empty, w_full, w_pop, w_push, w_drop, w_wr;
`ifdef COMMIT_TRACE_SKIP_X0_EN
  assign w_elig = debug_commit && (debug_reg_num != 5'd0);
`else
  assign w_elig = debug_commit;
`endif
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL);
  assign w_pop   = !w_empty && trace_ready;
  // a pop frees the head slot in the same edge, so a full FIFO still accepts
  assign w_push  = w_elig && (!w_full || w_pop);
  assign w_drop  = w_elig && w_full && !w_pop;
  assign w_wr    = w_push && !reset && !clear;
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_pc[r_wr_ptr] <= debug_pc;
      r_rd[r_wr_ptr] <= debug_reg_num;
      r_wd[r_wr_ptr] <= debug_wdata;
      r_sq[r_wr_ptr] <= r_seq;
    end
  end
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                 (!w_push && w_pop) ? r_count - 1'b1 : r_count;
      if (w_elig) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop) begin
        r_drop <= (&r_drop) ? r_drop : r_drop + SEQ_W'(1);
        r_ovf  <= 1'b1;
      end
    end
  end
  assign trace_valid   = !w_empty;
  assign trace_pc      = w_empty ? '0 : r_pc[r_rd_ptr];
  assign trace_reg_num = w_empty ? '0 : r_rd[r_rd_ptr];
  assign trace_wdata   = w_empty ? '0 : r_wd[r_rd_ptr];
  assign trace_seq     = w_empty ? '0 : r_sq[r_rd_ptr];
  assign count         = r_count;
  assign overflow      = r_ovf;
  assign drop_cnt      = r_drop;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo: randomized and directed checks of commit_trace_fifo against a queue-based model.
module tb_commit_trace_fifo;
  localparam int DEPTH = 16;
  logic        clock = 1'b0;
  logic        reset, debug_commit, clear, trace_ready;
  logic [63:0] debug_pc, debug_wdata;
  logic [4:0]  debug_reg_num;
  logic        trace_valid, overflow;
  logic [63:0] trace_pc, trace_wdata;
  logic [4:0]  trace_reg_num;
  logic [31:0] trace_seq, drop_cnt;
  logic [4:0]  count;
  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic [31:0] seq;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_seq, m_drop;
  logic        m_ovf;
  int          n_chk = 0, n_pass = 0;
  commit_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(32)) dut (
    .clock(clock), .reset(reset), .debug_commit(debug_commit), .debug_pc(debug_pc),
    .debug_reg_num(debug_reg_num), .debug_wdata(debug_wdata), .clear(clear),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_reg_num(trace_reg_num), .trace_wdata(trace_wdata), .trace_seq(trace_seq),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic eligible(input logic c, input logic [4:0] rd);
`ifdef COMMIT_TRACE_SKIP_X0_EN
    return c && rd != 5'd0;
`else
    return c;
`endif
  endfunction
  // outputs are registered-state only, so they are compared before the edge that consumes the inputs
  task automatic cyc(input logic c, input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] wd,
                     input logic rdy, input logic clr, input logic rst);
    debug_commit = c; debug_pc = pc; debug_reg_num = rd; debug_wdata = wd;
    trace_ready = rdy; clear = clr; reset = rst;
    #1;
    chk("valid", trace_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("pc", trace_pc, q.size() ? q[0].pc : 64'd0);
    chk("rd", trace_reg_num, q.size() ? q[0].rd : 5'd0);
    chk("wd", trace_wdata, q.size() ? q[0].wd : 64'd0);
    chk("seq", trace_seq, q.size() ? q[0].seq : 32'd0);
    if (rst || clr) begin
      q.delete(); m_seq = 0; m_drop = 0; m_ovf = 0;
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (eligible(c, rd)) begin
        if (q.size() < DEPTH) q.push_back('{pc, rd, wd, m_seq});
        else begin
          m_ovf = 1;
          if (m_drop != 32'hffff_ffff) m_drop++;
        end
        m_seq++;
      end
    end
    @(posedge clock); #1;
  endtask
  task automatic commit(input logic rdy);
    cyc(1'b1, {$urandom, $urandom}, 5'($urandom_range(1, 31)), {$urandom, $urandom}, rdy, 1'b0, 1'b0);
  endtask
  task automatic idle(input logic rdy);
    cyc(1'b0, 64'd0, 5'd0, 64'd0, rdy, 1'b0, 1'b0);
  endtask
  initial begin
    debug_commit = 0; debug_pc = 0; debug_reg_num = 0; debug_wdata = 0;
    trace_ready = 0; clear = 0; reset = 1;
    q.delete(); m_seq = 0; m_drop = 0; m_ovf = 0;
    repeat (2) @(posedge clock);
    #1;
    // T1: single commit, held while not ready
    cyc(1'b1, 64'h8000_0000, 5'd5, 64'h1234, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", trace_valid, 1);
    chk("t1_seq", trace_seq, 0);
    chk("t1_pc", trace_pc, 64'h8000_0000);
    repeat (3) idle(1'b0);
    idle(1'b1);
    // T2: overfill
    repeat (20) commit(1'b0);
    chk("t2_count", count, 16);
    chk("t2_drop", drop_cnt, 4);
    chk("t2_ovf", overflow, 1);
    // T3: full with simultaneous push and pop
    commit(1'b1);
    chk("t3_count", count, 16);
    chk("t3_drop", drop_cnt, 4);
    repeat (17) idle(1'b1);
    chk("drain_empty", count, 0);
    // T4: streaming across pointer wrap
    repeat (40) commit(1'b1);
    chk("t4_count", count, 1);
    idle(1'b1);
    // T5: clear beats a same-cycle commit
    repeat (3) commit(1'b0);
    cyc(1'b1, 64'h40, 5'd9, 64'h99, 1'b0, 1'b1, 1'b0);
    chk("t5_count", count, 0);
    chk("t5_ovf", overflow, 0);
    commit(1'b0);
    chk("t5_seq", trace_seq, 0);
    // T6: x0 destination handling
    cyc(1'b1, 64'h0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 64'h100, 5'd0, 64'h1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h104, 5'd3, 64'h2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h108, 5'd0, 64'h3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h10c, 5'd7, 64'h4, 1'b0, 1'b0, 1'b0);
`ifdef COMMIT_TRACE_SKIP_X0_EN
    chk("t6_count", count, 2);
    chk("t6_rd", trace_reg_num, 3);
`else
    chk("t6_count", count, 4);
    chk("t6_rd", trace_reg_num, 0);
`endif
    // randomized phases with varying commit/ready pressure, occasional clear and reset
    for (int p = 0; p < 12; p++) begin
      int pc_c, pc_r;
      pc_c = $urandom_range(10, 100);
      pc_r = $urandom_range(0, 100);
      for (int i = 0; i < 300; i++)
        cyc(($urandom % 100) < pc_c, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
            ($urandom % 100) < pc_r, ($urandom % 200) == 0, ($urandom % 400) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
